decode_stage: RTL and testbench

//  Parametrised pipelined decode stage: splits instr into fields, generates control, reads the register file.

---
 rtl/decode_pkg.sv | 25 ++
 rtl/decode_regfile.sv | 32 +++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-stage types: opcode encoding, MEM-class sub-operations
// and the control bundle handed to execute/mem.
package decode_pkg;

  typedef enum logic [1:0] {
    OP_R   = 2'b00,
    OP_MEM = 2'b01,
    OP_JMP = 2'b10,
    OP_NOP = 2'b11
  } opcode_e;

  localparam logic [1:0] SUB_ADDI = 2'b00;
  localparam logic [1:0] SUB_LD   = 2'b01;
  localparam logic [1:0] SUB_ST   = 2'b10;
  localparam logic [1:0] SUB_WR3  = 2'b11;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic pc_src;
  } ctrl_t;

endpackage

// File: rtl/decode_regfile.sv
// NUM_REGS x DATA_W register file, two read ports and one write port;
// a same-cycle write is forwarded to the read ports.
module decode_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, control generation, register read, busy
// scoreboard with RAW/WAW stall, and a valid/ready output register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  NUM_REGS = 4,
  parameter int  IMM_W    = 2,
  localparam int REG_AW   = $clog2(NUM_REGS),
  localparam int INSTR_W  = 2 + 2*REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_rd1,
  output logic [DATA_W-1:0]  out_rd2,
  output logic [REG_AW-1:0]  out_dest,
  output logic [IMM_W-1:0]   out_imm,
  output ctrl_t              out_ctrl
);

  opcode_e             op;
  logic [REG_AW-1:0]   rs, rt;
  logic [IMM_W-1:0]    imm;
  ctrl_t               ctrl;
  logic                use_rs, use_rt;
  logic [DATA_W-1:0]   rf_rd1, rf_rd2;
  logic [NUM_REGS-1:0] busy_q, busy_d, wb_mask, busy_eff;
  logic                hazard, accept;

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  ctrl_t               ctrl_q, ctrl_d;

  assign op  = opcode_e'(instr[INSTR_W-1 -: 2]);
  assign rs  = instr[INSTR_W-3 -: REG_AW];
  assign rt  = instr[IMM_W+REG_AW-1 -: REG_AW];
  assign imm = instr[IMM_W-1:0];

  // For the MEM class the rs field is a sub-opcode, not a register.
  always_comb begin
    ctrl   = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (op)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_MEM: begin
        case (rs)
          REG_AW'(SUB_ADDI): ctrl.reg_write = 1'b1;
          REG_AW'(SUB_LD): begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
          end
          REG_AW'(SUB_ST): begin
            ctrl.mem_write = 1'b1;
            use_rt         = 1'b1;
          end
          REG_AW'(SUB_WR3): ctrl.reg_write = 1'b1;
          default: ctrl = '0;
        endcase
      end
      OP_JMP: ctrl.pc_src = 1'b1;
      OP_NOP: ctrl = '0;
    endcase
  end

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_addr] = 1'b1;
  end

  assign busy_eff = busy_q & ~wb_mask;
  assign hazard   = in_valid & ((use_rs & busy_eff[rs]) | (use_rt & busy_eff[rt]) |
                                (ctrl.reg_write & busy_eff[rt]));
  assign in_ready = ~hazard & (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  decode_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (wb_valid),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  // Order matters: wb clear, then flush release, then accept set (set wins).
  always_comb begin
    busy_d = busy_eff;
    if (flush && out_valid_q && ctrl_q.reg_write) busy_d[dest_q] = 1'b0;
    if (accept && ctrl.reg_write) busy_d[rt] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    dest_d      = dest_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      rd1_d       = rf_rd1;
      rd2_d       = rf_rd2;
      dest_d      = rt;
      imm_d       = imm;
      ctrl_d      = ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      dest_q      <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      dest_q      <= dest_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd1   = rd1_q;
  assign out_rd2   = rd2_q;
  assign out_dest  = dest_q;
  assign out_imm   = imm_q;
  assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against a cycle-level
// behavioural model of the decode/scoreboard/handshake rules.
module tb_decode_stage;
  import decode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, wb_valid, flush, out_valid, out_ready;
  logic [7:0] instr, wb_data, out_rd1, out_rd2;
  logic [1:0] wb_addr, out_dest, out_imm;
  ctrl_t      out_ctrl;

  decode_stage #(.DATA_W(8), .NUM_REGS(4), .IMM_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_dest(out_dest),
    .out_imm(out_imm), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_regs [4];
  bit         m_busy [4];
  bit         m_ov;
  logic [7:0] m_rd1, m_rd2;
  logic [1:0] m_dest, m_imm;
  logic [4:0] m_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
    m_ov = 1'b0; m_rd1 = 8'h00; m_rd2 = 8'h00;
    m_dest = 2'd0; m_imm = 2'd0; m_ctrl = 5'd0;
  endtask

  // ctrl bits {reg_write, mem_read, mem_write, mem_to_reg, pc_src}
  function automatic void decode(input logic [7:0] ins, output logic [4:0] c,
                                 output bit urs, output bit urt);
    logic [1:0] op, sub;
    op = ins[7:6]; sub = ins[5:4];
    urs = 1'b0; urt = 1'b0; c = 5'b00000;
    if (op == 2'd0) begin c = 5'b10000; urs = 1'b1; urt = 1'b1; end
    else if (op == 2'd1) begin
      if (sub == 2'd1)      c = 5'b11010;
      else if (sub == 2'd2) begin c = 5'b00100; urt = 1'b1; end
      else                  c = 5'b10000;
    end
    else if (op == 2'd2) c = 5'b00001;
  endfunction

  task automatic step(input bit iv, input logic [7:0] ins, input bit ordy,
                      input bit wv, input logic [1:0] wa, input logic [7:0] wd,
                      input bit fl);
    logic [4:0] c;
    bit urs, urt, exp_ready, acc, hz;
    int rs, rt;
    in_valid = iv; instr = ins; out_ready = ordy;
    wb_valid = wv; wb_addr = wa; wb_data = wd; flush = fl;
    #1;
    decode(ins, c, urs, urt);
    rs = int'(ins[5:4]); rt = int'(ins[3:2]);
    hz = iv && ((urs && m_busy[rs] && !(wv && int'(wa) == rs)) ||
                ((urt || c[4]) && m_busy[rt] && !(wv && int'(wa) == rt)));
    exp_ready = !hz && (!m_ov || ordy) && !fl;
    chk("in_ready", in_ready, exp_ready);
    acc = iv && exp_ready;
    if (fl && m_ov && m_ctrl[4]) m_busy[m_dest] = 1'b0;
    if (acc) begin
      m_rd1  = (wv && int'(wa) == rs) ? wd : m_regs[rs];
      m_rd2  = (wv && int'(wa) == rt) ? wd : m_regs[rt];
      m_dest = ins[3:2]; m_imm = ins[1:0]; m_ctrl = c;
    end
    if (wv) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
    if (acc && c[4]) m_busy[rt] = 1'b1;
    if (acc)              m_ov = 1'b1;
    else if (fl)          m_ov = 1'b0;
    else if (m_ov && ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_rd1", out_rd1, m_rd1);
      chk("out_rd2", out_rd2, m_rd2);
      chk("out_dest", out_dest, m_dest);
      chk("out_imm", out_imm, m_imm);
      chk("out_ctrl", out_ctrl, m_ctrl);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 8'h00; out_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = 2'd0; wb_data = 8'h00; flush = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rd1", out_rd1, 8'h00);
    chk("rst_rd2", out_rd2, 8'h00);
    chk("rst_dest", out_dest, 2'd0);
    chk("rst_imm", out_imm, 2'd0);
    chk("rst_ctrl", out_ctrl, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: R-type writing r2
    step(1, 8'b00_01_10_00, 1, 0, 2'd0, 8'h00, 0);
    chk("t1_dest", out_dest, 2'd2);
    chk("t1_reg_write", out_ctrl.reg_write, 1'b1);

    // 2: RAW on r2 stalls until writeback, operand forwarded
    step(1, 8'b00_10_11_00, 1, 0, 2'd0, 8'h00, 0);
    chk("t2_stall", in_ready, 1'b0);
    step(1, 8'b00_10_11_00, 1, 0, 2'd0, 8'h00, 0);
    step(1, 8'b00_10_11_00, 1, 1, 2'd2, 8'h5A, 0);
    chk("t2_fwd_rd1", out_rd1, 8'h5A);

    // 3: backpressure holds bundle, then back-to-back transfer
    for (int i = 0; i < 3; i++) begin
      step(1, 8'b11_00_00_00, 0, 0, 2'd0, 8'h00, 0);
      chk("t3_hold_rd1", out_rd1, 8'h5A);
    end
    step(1, 8'b11_00_00_00, 1, 0, 2'd0, 8'h00, 0);
    chk("t3_b2b_valid", out_valid, 1'b1);
    chk("t3_b2b_ctrl", out_ctrl, 5'b00000);

    // 4: LD (WAW on busy r3 first), ST stalled on r3, JMP
    step(1, 8'b01_01_11_00, 1, 0, 2'd0, 8'h00, 0);
    step(1, 8'b01_01_11_00, 1, 1, 2'd3, 8'hC3, 0);
    chk("t4_ld_ctrl", out_ctrl, 5'b11010);
    step(1, 8'b01_10_11_00, 1, 0, 2'd0, 8'h00, 0);
    chk("t4_st_stall", in_ready, 1'b0);
    step(1, 8'b01_10_11_00, 1, 0, 2'd0, 8'h00, 0);
    step(1, 8'b10_00_00_00, 1, 0, 2'd0, 8'h00, 0);
    chk("t4_jmp_ctrl", out_ctrl, 5'b00001);

    // 5: flush a held bundle writing r1
    step(1, 8'b00_00_01_00, 1, 0, 2'd0, 8'h00, 0);
    step(0, 8'h00, 0, 0, 2'd0, 8'h00, 0);
    step(1, 8'b11_00_00_00, 0, 0, 2'd0, 8'h00, 1);
    chk("t5_flush_valid", out_valid, 1'b0);
    step(1, 8'b00_01_00_00, 0, 0, 2'd0, 8'h00, 0);
    chk("t5_r1_free", out_valid, 1'b1);

    // 6: asynchronous reset during a stall
    in_valid = 1'b1; instr = 8'b01_10_11_00; out_ready = 1'b0;
    wb_valid = 1'b0; flush = 1'b0;
    #1;
    chk("t6_stalled", in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_ctrl", out_ctrl, 5'd0);
    chk("t6_async_dest", out_dest, 2'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 8'b00_10_11_00, 1, 0, 2'd0, 8'h00, 0);
    chk("t6_r2_zero", out_rd1, 8'h00);
    chk("t6_r3_zero", out_rd2, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 4), 2'($urandom), 8'($urandom),
           ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
